// File: rtl/mux_nx1_pipe.sv
// -----------------------------------------------------------------------------
// mux_nx1_pipe
//
// Registered N-to-1 result multiplexer for the rv32i_core execute/writeback
// boundary. One of N_IN packed data inputs is chosen by in_sel. The chosen
// word, the select that produced it and an "illegal select" flag travel
// together as one beat through a valid/ready pipeline stage. The stage is an
// output register backed by a one-entry skid buffer.
//
// Handshake semantics (both sides):
//   A beat transfers on a rising clk edge where valid and ready are both 1.
//   A producer holding valid=1 keeps its payload stable until the transfer.
//   in_ready is a flop (= ~skid_full) and never depends on out_ready in the
//   same cycle, so the upstream timing path stops at this block.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_flat       N_IN packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel        select for the beat offered this cycle
//   in_valid      producer offers a beat
//   in_ready      block can take a beat this cycle
//   out_data      selected word (DEFAULT_VAL for an out-of-range select)
//   out_sel       select that produced out_data
//   out_illegal   out_data came from an out-of-range select
//   out_valid     output beat present
//   out_ready     consumer takes the beat
//   clr_err       synchronous clear of err_sticky / err_cnt
//   err_sticky    an illegal select was accepted since the last clear
//   err_cnt       saturating count of accepted illegal selects
// -----------------------------------------------------------------------------
module mux_nx1_pipe #(
    parameter int                WIDTH       = 32,
    parameter int                N_IN        = 8,
    parameter int                SEL_W       = 4,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
    parameter int                CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_flat,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_illegal,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clr_err,
    output logic                    err_sticky,
    output logic [CNT_W-1:0]        err_cnt
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity.
    // -------------------------------------------------------------------------
    if (N_IN < 2 || N_IN > 16 || (1 << SEL_W) < N_IN) begin : g_bad_params
        $error("mux_nx1_pipe: N_IN must be 2..16 and 2**SEL_W >= N_IN");
    end

    // One extra bit so the compare also works when 2**SEL_W == N_IN.
    localparam logic [SEL_W:0]   N_IN_EXT = (SEL_W + 1)'(N_IN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // -------------------------------------------------------------------------
    // Combinational select of the offered beat.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sel_data;
    logic             sel_illegal;

    always_comb begin
        sel_data    = DEFAULT_VAL;
        sel_illegal = ({1'b0, in_sel} >= N_IN_EXT);
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline control.
    //   acc   : input handshake this cycle
    //   drain : output handshake this cycle
    // A beat only goes to the skid entry when the output register is full and
    // is not being drained; since in_ready = ~skid_full, an accept can never
    // coincide with an occupied skid entry.
    // -------------------------------------------------------------------------
    logic skid_full;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_illegal;

    logic acc;
    logic drain;
    logic load_out_from_in;
    logic load_out_from_skid;
    logic load_skid;
    logic out_valid_nxt;
    logic skid_full_nxt;

    assign acc   = in_valid & in_ready;
    assign drain = out_valid & out_ready;

    always_comb begin
        load_out_from_skid = skid_full & drain;
        load_out_from_in   = acc & (~out_valid | drain);
        load_skid          = acc & out_valid & ~drain;
        skid_full_nxt      = load_skid | (skid_full & ~drain);
        out_valid_nxt      = load_out_from_skid | load_out_from_in
                           | (out_valid & ~drain);
    end

    // Output register, skid entry and the registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sel      <= '0;
            out_illegal  <= 1'b0;
            skid_full    <= 1'b0;
            skid_data    <= '0;
            skid_sel     <= '0;
            skid_illegal <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            out_valid <= out_valid_nxt;
            skid_full <= skid_full_nxt;
            in_ready  <= ~skid_full_nxt;

            // The skid beat is older than anything on the input, so it has
            // priority for the output register (FIFO order).
            if (load_out_from_skid) begin
                out_data    <= skid_data;
                out_sel     <= skid_sel;
                out_illegal <= skid_illegal;
            end else if (load_out_from_in) begin
                out_data    <= sel_data;
                out_sel     <= in_sel;
                out_illegal <= sel_illegal;
            end

            if (load_skid) begin
                skid_data    <= sel_data;
                skid_sel     <= in_sel;
                skid_illegal <= sel_illegal;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Illegal-select tracking. An illegal accept in the same cycle as clr_err
    // counts as the first event after the clear, so the set wins.
    // -------------------------------------------------------------------------
    logic             err_sticky_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;

    always_comb begin
        err_sticky_nxt = err_sticky;
        err_cnt_nxt    = err_cnt;
        if (acc & sel_illegal) begin
            err_sticky_nxt = 1'b1;
            if (clr_err) begin
                err_cnt_nxt = CNT_W'(1);
            end else if (err_cnt != CNT_MAX) begin
                err_cnt_nxt = err_cnt + CNT_W'(1);
            end
        end else if (clr_err) begin
            err_sticky_nxt = 1'b0;
            err_cnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err_sticky <= err_sticky_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
module tb_mux_nx1_pipe;

    localparam int          WIDTH     = 32;
    localparam int          N_IN      = 8;
    localparam int          SEL_W     = 4;
    localparam int          CNT_W     = 8;
    localparam logic [31:0] A_DEFAULT = 32'hDEAD_BEEF;
    localparam int          B_N_IN    = 5;
    localparam int          B_SEL_W   = 3;
    localparam int          W         = WIDTH + SEL_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT A (N_IN=8, SEL_W=4) ----------------
    logic [N_IN*WIDTH-1:0] in_flat;
    logic [SEL_W-1:0]      in_sel = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_illegal;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic                  clr_err = 1'b0;
    logic                  err_sticky;
    logic [CNT_W-1:0]      err_cnt;

    mux_nx1_pipe #(
        .WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W),
        .DEFAULT_VAL(A_DEFAULT), .CNT_W(CNT_W)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_flat(in_flat), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_illegal(out_illegal),
        .out_valid(out_valid), .out_ready(out_ready),
        .clr_err(clr_err), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    // ---------------- DUT B (N_IN=5, SEL_W=3, default value 0) ----------------
    logic [B_N_IN*WIDTH-1:0] b_in_flat;
    logic [B_SEL_W-1:0]      b_in_sel = '0;
    logic                    b_in_valid = 1'b0;
    logic                    b_in_ready;
    logic [WIDTH-1:0]        b_out_data;
    logic [B_SEL_W-1:0]      b_out_sel;
    logic                    b_out_illegal;
    logic                    b_out_valid;
    logic                    b_out_ready = 1'b1;
    logic                    b_clr_err = 1'b0;
    logic                    b_err_sticky;
    logic [CNT_W-1:0]        b_err_cnt;

    mux_nx1_pipe #(
        .WIDTH(WIDTH), .N_IN(B_N_IN), .SEL_W(B_SEL_W),
        .DEFAULT_VAL(32'h0000_0000), .CNT_W(CNT_W)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_flat(b_in_flat), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_illegal(b_out_illegal),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .clr_err(b_clr_err), .err_sticky(b_err_sticky), .err_cnt(b_err_cnt)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    bit           lat_en = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        int           pc;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got beat 0x%0h with nothing expected (t=%0t)",
                         {out_data, out_sel, out_illegal}, $time);
            end else begin
                e  = exp_q.pop_front();
                pc = exp_cyc_q.pop_front();
                check("sb_beat", 64'({out_data, out_sel, out_illegal}), 64'(e));
                if (lat_en) check("sb_latency", 64'(cyc - pc), 64'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat on DUT A, push its expectation when the handshake is seen,
    // and return one time unit after the accepting edge.
    task automatic send(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d,
                        input logic il, output int waits);
        bit done;
        done     = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_sel   = s;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({d, s, il});
                exp_cyc_q.push_back(cyc);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: sel %0d never accepted, in_ready=%0b expected 1", s, in_ready);
        end
        in_valid = 1'b0;
        in_sel   = SEL_W'($urandom);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
        logic             ill;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int w;
        int total_waits;

        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
        w = 0; total_waits = 0;
    end

    initial begin
        int w;
        int total_waits;

        for (int k = 0; k < N_IN; k++)   in_flat[k*WIDTH +: WIDTH]   = 32'h1000_0000 + k;
        for (int k = 0; k < B_N_IN; k++) b_in_flat[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
        for (int k = 0; k < 8; k++) vecs[k] = '{SEL_W'(k), 32'h1000_0000 + k, 1'b0};
        vecs[8]  = '{4'd9,  A_DEFAULT,     1'b1};
        vecs[9]  = '{4'd15, A_DEFAULT,     1'b1};
        vecs[10] = '{4'd3,  32'h1000_0003, 1'b0};
        vecs[11] = '{4'd8,  A_DEFAULT,     1'b1};

        // ---- reset state ----
        repeat (2) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_err_sticky", 64'(err_sticky), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // ---- single beat, one-cycle latency ----
        lat_en = 1'b1;
        send(4'd5, 32'h1000_0005, 1'b0, w);
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_out_data", 64'(out_data), 64'h1000_0005);
        tick();
        check("single_out_valid_drop", 64'(out_valid), 64'd0);

        // ---- table: back-to-back beats incl. illegal selects ----
        total_waits = 0;
        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].data, vecs[i].ill, w);
            total_waits += w;
        end
        repeat (3) tick();
        check("b2b_no_stall", 64'(total_waits), 64'd0);
        check("b2b_drained", 64'(exp_q.size()), 64'd0);
        check("a_err_cnt", 64'(err_cnt), 64'd3);
        check("a_err_sticky", 64'(err_sticky), 64'd1);
        lat_en = 1'b0;

        // ---- stall: fill output register and skid ----
        out_ready = 1'b0;
        send(4'd1, 32'h1000_0001, 1'b0, w);
        check("stall_in_ready_first", 64'(in_ready), 64'd1);
        send(4'd2, 32'h1000_0002, 1'b0, w);
        check("stall_in_ready_low", 64'(in_ready), 64'd0);
        check("stall_out_data", 64'(out_data), 64'h1000_0001);
        // Offer a beat that must not be taken while the skid is full.
        in_valid = 1'b1;
        in_sel   = 4'd4;
        repeat (3) tick();
        in_valid = 1'b0;
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_data", 64'({out_data, out_sel}), 64'({32'h1000_0001, 4'd1}));
        out_ready = 1'b1;
        repeat (3) tick();
        check("stall_in_ready_back", 64'(in_ready), 64'd1);
        check("stall_drained", 64'(exp_q.size()), 64'd0);
        check("stall_out_valid_end", 64'(out_valid), 64'd0);

        // ---- DUT B: illegal select, saturation, clear ----
        check("b_in_ready", 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b1;
        b_in_sel   = 3'd6;
        tick();
        b_in_valid = 1'b0;
        check("b_ill_out", 64'({b_out_valid, b_out_data, b_out_sel, b_out_illegal}),
              64'({1'b1, 32'h0, 3'd6, 1'b1}));
        check("b_ill_sticky", 64'(b_err_sticky), 64'd1);
        check("b_ill_cnt", 64'(b_err_cnt), 64'd1);
        b_in_valid = 1'b1;
        for (int i = 0; i < 253; i++) begin
            b_in_sel = 3'($urandom_range(5, 7));
            tick();
        end
        b_in_valid = 1'b0;
        check("b_cnt_254", 64'(b_err_cnt), 64'd254);
        b_in_valid = 1'b1;
        for (int i = 0; i < 47; i++) begin
            b_in_sel = 3'($urandom_range(5, 7));
            tick();
        end
        b_in_valid = 1'b0;
        check("b_cnt_sat", 64'(b_err_cnt), 64'd255);
        b_in_valid = 1'b1;
        b_in_sel   = 3'd4;
        tick();
        b_in_valid = 1'b0;
        check("b_legal_out", 64'({b_out_data, b_out_illegal}), 64'({32'h1000_0004, 1'b0}));
        check("b_legal_cnt_held", 64'(b_err_cnt), 64'd255);

        b_clr_err = 1'b1;
        tick();
        b_clr_err = 1'b0;
        check("b_clr_cnt", 64'(b_err_cnt), 64'd0);
        b_in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_in_sel = 3'($urandom_range(5, 7));
            tick();
        end
        check("b_cnt_7", 64'(b_err_cnt), 64'd7);
        b_in_sel  = 3'd5;
        b_clr_err = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("b_clr_vs_set", 64'({b_err_sticky, b_err_cnt}), 64'({1'b1, 8'd1}));
        tick();
        b_clr_err = 1'b0;
        check("b_clr_alone", 64'({b_err_sticky, b_err_cnt}), 64'({1'b0, 8'd0}));

        // ---- reset with skid full ----
        out_ready = 1'b0;
        send(4'd6, 32'h1000_0006, 1'b0, w);
        send(4'd7, 32'h1000_0007, 1'b0, w);
        check("pre_rst_skid_full", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        #4;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        lat_en = 1'b1;
        send(4'd3, 32'h1000_0003, 1'b0, w);
        repeat (3) tick();
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised, registered N-to-1 result multiplexer for the rv32i_core datapath.
- Generalises the fixed 5-input combinational mux: configurable width and input count, one-cycle registered output, and a valid/ready handshake with a one-entry skid buffer so a stalled consumer never drops a beat.
- Also flags and counts out-of-range selects.
- Sits between the execute-stage result sources (ALU, PC+4, immediate, load data, CSR) and the writeback register.

Parameters:
- WIDTH, 32, data width of each input and of the output
- N_IN, 8, number of data inputs; legal range is 2..16
- SEL_W, 4, select width; must satisfy 2^SEL_W >= N_IN
- DEFAULT_VAL, 32'h0000_0000, value driven for an out-of-range select (WIDTH bits)
- CNT_W, 8, width of the illegal-select event counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_flat  input  N_IN*WIDTH  packed data inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  select for the current beat
- in_valid  input  1  producer has a beat
- in_ready  output  1  block can accept a beat
- out_data  output  WIDTH  selected data
- out_sel  output  SEL_W  select value that produced out_data
- out_illegal  output  1  current output beat came from an out-of-range select
- out_valid  output  1  output beat present
- out_ready  input  1  consumer accepts the beat
- clr_err  input  1  synchronous clear of err_sticky and err_cnt
- err_sticky  output  1  an illegal select has been accepted since the last clear
- err_cnt  output  CNT_W  saturating count of accepted illegal selects

Behaviour:
- Reset, asynchronous on rst high: out_valid=0, in_ready=1, out_data=0, out_sel=0, out_illegal=0, err_sticky=0, err_cnt=0, skid entry empty. No acceptance while rst is high.
- Handshakes:
  - Input handshake occurs when in_valid & in_ready.
  - Output handshake occurs when out_valid & out_ready.
- Selection (combinational, at accept time):
  - If in_sel < N_IN: data = in_flat[in_sel*WIDTH +: WIDTH], illegal = 0.
  - Otherwise: data = DEFAULT_VAL, illegal = 1.
  - {data, in_sel, illegal} are captured together as one beat.
- Latency: an accepted beat appears on the outputs on the next clock edge when the output register is empty or draining in that same cycle. Sustained throughput is 1 beat/cycle with out_ready held high.
- Storage: an output register plus one skid entry.
  - in_ready is a register output: in_ready = ~skid_full. It does not depend combinationally on out_ready.
  - Output register empty, or drained this cycle: the incoming beat loads the output register.
  - Output register full and not drained while in_ready=1: the incoming beat loads the skid entry; skid_full=1 and in_ready=0 from the next cycle.
  - Skid full and output drained: the skid beat moves to the output register; skid_full=0.
  - No input accept is possible while skid_full=1.
  - Order is strictly FIFO; no beat is ever duplicated or dropped.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_illegal hold constant.
- in_flat and in_sel are don't-care when the input handshake is not occurring.
- Error tracking:
  - Each accepted illegal beat sets err_sticky and increments err_cnt on the accepting edge.
  - err_cnt saturates at 2^CNT_W-1.
  - clr_err alone sets both to 0.
  - clr_err in the same cycle as an illegal accept: the set wins, giving err_sticky=1 and err_cnt=1.
- Reset mid-operation: all in-flight beats are discarded and outputs return to their reset values immediately (asynchronously).

Test Plan:
- Reset then N_IN=8, in_flat input k=32'h1000_0000+k, in_sel=5, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_data=32'h1000_0005, out_sel=5, out_illegal=0; following cycle out_valid=0.
- Back-to-back sel 0..7 on 8 consecutive cycles, out_ready=1 -> in_ready stays 1; outputs 32'h1000_0000..32'h1000_0007 on 8 consecutive cycles, one-cycle latency.
- Stall: sel=1 then sel=2 accepted with out_ready=0 -> in_ready drops to 0 after the second accept; out_data holds 32'h1000_0001. Raise out_ready -> 32'h1000_0001 then 32'h1000_0002; in_ready returns to 1.
- N_IN=5, SEL_W=3, in_sel=6 accepted -> out_data=32'h0, out_illegal=1, err_sticky=1, err_cnt=1. Then 300 illegal accepts with CNT_W=8 -> err_cnt=255.
- clr_err asserted in the same cycle as an illegal accept, with err_cnt=7 before -> err_sticky=1, err_cnt=1. clr_err alone next cycle -> err_sticky=0, err_cnt=0.
- With skid full and out_valid=1, assert rst for half a cycle -> out_valid=0, in_ready=1, err_cnt=0 immediately; the first post-reset beat (sel=3) emerges as 32'h1000_0003 with no stale data.
